scan_config_ctrl: RTL and testbench
===================================

Name: scan_config_ctrl

Overview:
- Sequences bitstream loading into the FPGA configuration scan chain, a serial chain of SIZE-bit configuration cells that shift MSB-out while scan_en is high.
- Accepts parallel configuration words over a valid/ready interface and serialises them MSB-first onto the chain, driving scan_en only while shifting.
- Captures the bits shifted out of the chain tail as readback words, so the previous configuration can be checked.
- Sits between the bitstream source (host/ROM loader) and the head of the scan chain.

Parameters:
- CHAIN_LEN, 16, total number of bits in the scan chain (sum of cell SIZEs); ≥ 1.
- DATA_W, 8, configuration word width; ≥ 1.
- CNT_W, $clog2(CHAIN_LEN+1), width of the remaining-bit counter.

Ports:
- scan_clk  in  1  sole clock; shared with the scan chain cells.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load (ignored unless idle).
- abort  in  1  terminates the load at the next edge.
- word_data  in  DATA_W  configuration word, MSB shifted first.
- word_valid  in  1  word_data valid.
- word_ready  out  1  controller accepts a word this cycle.
- scan_en  out  1  chain shift enable.
- scan_in  out  1  serial data into chain head.
- scan_out  in  1  serial data from chain tail.
- rdata  out  DATA_W  readback word.
- rdata_valid  out  1  one-cycle pulse; rdata valid.
- busy  out  1  high from start acceptance until return to IDLE.
- done  out  1  one-cycle pulse; all CHAIN_LEN bits shifted.

Behaviour:
- Reset (async, rst=1): state=IDLE; all outputs 0; internal shift/readback registers and counters 0. The chain contents are untouched (scan_en=0).
- States: IDLE, FETCH, SHIFT, DONE.
- IDLE: start=1 loads rem=CHAIN_LEN and moves to FETCH; busy=1 from the next cycle.
- FETCH: word_ready=1, scan_en=0.
  - On word_valid&&word_ready: load shreg=word_data, set wbits=min(DATA_W, rem), clear the readback register, go to SHIFT.
  - With no valid word, stay in FETCH; the chain holds (no timeout).
- SHIFT: scan_en=1, scan_in=shreg[DATA_W-1]; both are decoded directly from registers, with no combinational path from inputs.
  - Each edge: chain shifts one bit; shreg shifts left; rbk <= {rbk[DATA_W-2:0], scan_out} (samples the tail bit before the shift); wbits--, rem--.
  - When wbits reaches 1 at an edge (last bit of the word): rdata <= rbk-with-that-bit, left-aligned so that a partial word has unused low bits 0; rdata_valid=1 next cycle. Then go to DONE if rem reaches 0, otherwise FETCH.
- Throughput: DATA_W shift cycles plus ≥1 FETCH cycle per word. scan_en is low for at least 1 cycle between words.
- Partial last word (CHAIN_LEN % DATA_W ≠ 0): only the top rem bits of the final word are shifted; its low bits are discarded.
- DONE: done=1 for one cycle, then IDLE; busy drops the cycle after DONE.
- start while busy: ignored.
- abort=1 in any non-IDLE state: next state IDLE, scan_en=0 immediately after the edge. No done and no rdata_valid for the partial word. The chain keeps its partially shifted contents. abort has priority over the handshake and shifting at the same edge.
- Simultaneous start and abort in IDLE: stay IDLE.
- rst mid-operation: immediate IDLE and outputs 0; at most a partial shift of the chain.
- Total shifted bits per completed load = exactly CHAIN_LEN. The scan_en-high cycle count equals CHAIN_LEN.

Test Plan:
- CHAIN_LEN=16, DATA_W=8; start, words 0xA5 then 0x3C always valid -> scan_in sequence 1010010100111100; 16 scan_en cycles; done pulse; the chain model (16-bit) holds 0xA53C.
- Repeat the load with words 0xFF,0x00 after 0xA53C is loaded -> rdata_valid twice with rdata 0xA5 then 0x3C; chain holds 0xFF00.
- CHAIN_LEN=12, DATA_W=8; words 0xB7, 0x9F -> 12 scan_en cycles, chain=0xB79; second rdata low 4 bits 0; done after 4 shifts of the second word.
- word_valid held low for 5 cycles between words -> word_ready high, scan_en low for those cycles; chain value unchanged during the stall; final result is still correct.
- abort asserted at the 3rd shift of the first word -> IDLE next cycle, scan_en=0, busy=0, no done/rdata_valid; a subsequent start performs a full correct load.
- start pulsed while busy, plus rst asserted mid-SHIFT -> the start is ignored (single load); rst forces all outputs 0 asynchronously, and the next start loads correctly.

Source files
------------

// File: rtl/scan_config_ctrl.sv
// scan_config_ctrl
// Loads a configuration bitstream into the FPGA scan chain. Parallel words
// arrive over a valid/ready handshake. Each word is shifted MSB-first into
// the chain head. The bits that fall out of the chain tail are collected
// as readback words.
//
// Ports:
//   scan_clk    - sole clock, shared with the scan chain cells
//   rst         - asynchronous active-high reset
//   start       - one-cycle pulse, begins a load when idle
//   abort       - returns to idle at the next edge, highest priority
//   word_data   - configuration word (MSB shifted first)
//   word_valid  - word_data valid
//   word_ready  - controller accepts a word this cycle
//   scan_en     - chain shift enable
//   scan_in     - serial data into the chain head
//   scan_out    - serial data from the chain tail
//   rdata       - readback word, left-aligned
//   rdata_valid - one-cycle pulse, rdata valid
//   busy        - load in progress
//   done        - one-cycle pulse, all CHAIN_LEN bits shifted
module scan_config_ctrl #(
  parameter int CHAIN_LEN = 16,
  parameter int DATA_W    = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              scan_clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              scan_en,
  output logic              scan_in,
  input  logic              scan_out,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              busy,
  output logic              done
);

  localparam int WB_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] rbk_q, rbk_d;
  logic [WB_W-1:0]   wbits_q, wbits_d;
  logic [WB_W-1:0]   wpad_q, wpad_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rdata_valid_q, rdata_valid_d;
  logic [DATA_W-1:0] rbk_shift;

  always_ff @(posedge scan_clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      shreg_q       <= '0;
      rbk_q         <= '0;
      wbits_q       <= '0;
      wpad_q        <= '0;
      rem_q         <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      rbk_q         <= rbk_d;
      wbits_q       <= wbits_d;
      wpad_q        <= wpad_d;
      rem_q         <= rem_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
    end
  end

  // The tail bit is sampled on the same edge that shifts the chain.
  // The value seen is the bit present before that shift.
  assign rbk_shift = (rbk_q << 1) | DATA_W'(scan_out);

  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    rbk_d         = rbk_q;
    wbits_d       = wbits_q;
    wpad_d        = wpad_q;
    rem_d         = rem_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_FETCH;
          rem_d   = CNT_W'(CHAIN_LEN);
        end
      end

      S_FETCH: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (word_valid) begin
          state_d = S_SHIFT;
          shreg_d = word_data;
          rbk_d   = '0;
          // A short final word shifts only its top rem bits.
          // wpad is the amount that later left-aligns its readback.
          if (32'(rem_q) >= 32'(DATA_W)) begin
            wbits_d = WB_W'(DATA_W);
            wpad_d  = '0;
          end else begin
            wbits_d = WB_W'(rem_q);
            wpad_d  = WB_W'(DATA_W) - WB_W'(rem_q);
          end
        end
      end

      S_SHIFT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          shreg_d = shreg_q << 1;
          rbk_d   = rbk_shift;
          wbits_d = wbits_q - WB_W'(1);
          rem_d   = rem_q - CNT_W'(1);
          if (wbits_q == WB_W'(1)) begin
            rdata_d       = rbk_shift << wpad_q;
            rdata_valid_d = 1'b1;
            state_d       = (rem_q == CNT_W'(1)) ? S_DONE : S_FETCH;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign word_ready  = (state_q == S_FETCH);
  assign scan_en     = (state_q == S_SHIFT);
  assign scan_in     = (state_q == S_SHIFT) & shreg_q[DATA_W-1];
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;

endmodule

// File: tb/tb_scan_config_ctrl.sv
`timescale 1ns/1ps
module tb_scan_config_ctrl;

  localparam int DW   = 8;
  localparam int MAXC = 400;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, abort, word_valid, sel;
  logic [DW-1:0] word_data;
  logic          a_start, b_start;
  logic          a_ready, a_en, a_sin, a_rv, a_busy, a_done;
  logic          b_ready, b_en, b_sin, b_rv, b_busy, b_done;
  logic [DW-1:0] a_rdata, b_rdata;

  // Behavioural scan chains: MSB is the tail, new bits enter at bit 0.
  logic [15:0] chain_a = 16'h0F0F;
  logic [11:0] chain_b = 12'h5A3;
  always @(posedge clk) if (a_en) chain_a <= {chain_a[14:0], a_sin};
  always @(posedge clk) if (b_en) chain_b <= {chain_b[10:0], b_sin};

  assign a_start = start & ~sel;
  assign b_start = start & sel;

  scan_config_ctrl #(.CHAIN_LEN(16), .DATA_W(DW)) dut_a (
    .scan_clk(clk), .rst(rst), .start(a_start), .abort(abort),
    .word_data(word_data), .word_valid(word_valid), .word_ready(a_ready),
    .scan_en(a_en), .scan_in(a_sin), .scan_out(chain_a[15]),
    .rdata(a_rdata), .rdata_valid(a_rv), .busy(a_busy), .done(a_done));

  scan_config_ctrl #(.CHAIN_LEN(12), .DATA_W(DW)) dut_b (
    .scan_clk(clk), .rst(rst), .start(b_start), .abort(abort),
    .word_data(word_data), .word_valid(word_valid), .word_ready(b_ready),
    .scan_en(b_en), .scan_in(b_sin), .scan_out(chain_b[11]),
    .rdata(b_rdata), .rdata_valid(b_rv), .busy(b_busy), .done(b_done));

  // View of the DUT under test
  logic          s_ready, s_en, s_sin, s_rv, s_busy, s_done;
  logic [DW-1:0] s_rdata;
  logic [15:0]   s_chain;
  int            L;
  always_comb begin
    if (sel) begin
      s_ready = b_ready; s_en = b_en; s_sin = b_sin; s_rv = b_rv;
      s_busy = b_busy; s_done = b_done; s_rdata = b_rdata;
      s_chain = {4'h0, chain_b}; L = 12;
    end else begin
      s_ready = a_ready; s_en = a_en; s_sin = a_sin; s_rv = a_rv;
      s_busy = a_busy; s_done = a_done; s_rdata = a_rdata;
      s_chain = chain_a; L = 16;
    end
  end

  int total = 0;
  int bad = 0;
  task automatic ck(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: words to load, chain contents before the load,
  // and bit/word counters.
  logic [DW-1:0] ld_words[2];
  logic [15:0]   old_chain;
  bit            m_busy, m_done, m_rv;
  int            m_rem, m_shl, m_sb, m_widx;
  logic [DW-1:0] m_rdat;

  function automatic logic exp_bit(input int k);
    logic [DW-1:0] w;
    w = ld_words[k / DW];
    return w[DW-1-(k % DW)];
  endfunction

  function automatic logic [DW-1:0] exp_rd(input int j);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < DW; i++) begin
      if (j * DW + i < L) r[DW-1-i] = old_chain[L-1-(j*DW+i)];
    end
    return r;
  endfunction

  function automatic logic [15:0] exp_chain();
    logic [15:0] r;
    r = '0;
    for (int k = 0; k < L; k++) r[L-1-k] = exp_bit(k);
    return r;
  endfunction

  initial begin
    bit nrv, ndn;
    m_busy = 0; m_done = 0; m_rv = 0; m_rem = 0; m_shl = 0; m_sb = 0; m_widx = 0;
    m_rdat = '0; old_chain = '0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_busy = 0; m_done = 0; m_rv = 0; m_shl = 0; m_rem = 0;
      end else begin
        nrv = 0; ndn = 0;
        if (!m_busy) begin
          if (start && !abort) begin
            m_busy = 1; m_rem = L; m_sb = 0; m_shl = 0; m_widx = 0;
            old_chain = s_chain;
          end
        end else if (abort || m_done) begin
          m_busy = 0; m_shl = 0;
        end else if (m_shl > 0) begin
          m_sb++; m_shl--; m_rem--;
          if (m_shl == 0) begin
            nrv = 1;
            m_rdat = exp_rd((m_sb - 1) / DW);
            ndn = (m_rem == 0);
          end
        end else if (word_valid) begin
          m_shl = (m_rem < DW) ? m_rem : DW;
          m_widx++;
        end
        m_rv = nrv; m_done = ndn;
      end
    end
  end

  int en_total = 0, done_total = 0, rv_total = 0;
  logic [DW-1:0] rd_seen[$];

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        ck("busy", s_busy, m_busy);
        ck("scan_en", s_en, m_shl > 0);
        ck("word_ready", s_ready, m_busy && m_shl == 0 && m_rem > 0);
        ck("done", s_done, m_done);
        ck("rdata_valid", s_rv, m_rv);
        if (m_rv) ck("rdata", s_rdata, m_rdat);
        if (m_shl > 0) ck("scan_in", s_sin, exp_bit(m_sb));
        if (m_done) ck("chain", s_chain, exp_chain());
        if (s_en) en_total++;
        if (s_done) done_total++;
        if (s_rv) begin rv_total++; rd_seen.push_back(s_rdata); end
      end
    end
  end

  task automatic do_load(input int vprob, input int abort_at, input int mstart_at,
                         input int rst_at, input bit stall5);
    int cyc, en0, dn0, rv0, nst;
    bit hit;
    logic [15:0] ch0;
    en0 = en_total; dn0 = done_total; rv0 = rv_total;
    hit = 0; nst = 0; cyc = 0; ch0 = '0;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    while (m_busy && cyc < MAXC) begin
      word_data  = ld_words[(m_widx > 1) ? 1 : m_widx];
      word_valid = ($urandom_range(99) < vprob);
      start = (mstart_at >= 0 && m_shl > 0 && m_sb == mstart_at);
      abort = 0;
      if (abort_at >= 0 && !hit && m_shl > 0 && m_sb == abort_at) begin
        abort = 1; hit = 1;
      end
      if (stall5 && m_widx == 1 && m_shl == 0 && !m_done && nst < 5) begin
        if (nst == 0) ch0 = s_chain;
        word_valid = 0; nst++;
      end
      if (rst_at >= 0 && m_shl > 0 && m_sb == rst_at) begin
        rst = 1; #1;
        ck("arst_busy", s_busy, 0);
        ck("arst_scan_en", s_en, 0);
        ck("arst_ready", s_ready, 0);
        ck("arst_done", s_done, 0);
        ck("arst_rv", s_rv, 0);
        ck("arst_rdata", s_rdata, 0);
        @(posedge clk); #1;
        rst = 0;
        break;
      end
      @(posedge clk); #1;
      cyc++;
      if (stall5 && nst == 5) begin ck("stall_chain", s_chain, ch0); nst = 6; end
    end
    start = 0; abort = 0; word_valid = 0;
    if (cyc >= MAXC) begin
      total++; bad++;
      $display("FAIL load_timeout cycles=%0d limit=%0d", cyc, MAXC);
    end else if (rst_at < 0) begin
      if (abort_at < 0) begin
        ck("en_cycles", en_total - en0, L);
        ck("done_count", done_total - dn0, 1);
        ck("rv_count", rv_total - rv0, (L + DW - 1) / DW);
      end else begin
        ck("abort_busy", s_busy, 0);
        ck("abort_scan_en", s_en, 0);
        repeat (3) @(posedge clk);
        #1;
        ck("abort_no_done", done_total - dn0, 0);
        ck("abort_rv_count", rv_total - rv0, abort_at / DW);
      end
    end
  endtask

  initial begin
    int r0, lc, ab;
    rst = 0; start = 0; abort = 0; word_valid = 0; word_data = '0; sel = 0;
    ld_words[0] = '0; ld_words[1] = '0;
    #2 rst = 1;
    @(posedge clk); @(posedge clk); #1;
    ck("rst_busy_a", a_busy, 0); ck("rst_en_a", a_en, 0);
    ck("rst_ready_a", a_ready, 0); ck("rst_done_a", a_done, 0);
    ck("rst_rv_a", a_rv, 0); ck("rst_rdata_a", a_rdata, 0);
    ck("rst_busy_b", b_busy, 0); ck("rst_rdata_b", b_rdata, 0);
    rst = 0;
    @(posedge clk); #1;

    // 16-bit chain: A5,3C then FF,00 with readback of the first load
    ld_words[0] = 8'hA5; ld_words[1] = 8'h3C;
    do_load(100, -1, -1, -1, 0);
    ck("chain_A53C", chain_a, 16'hA53C);
    ld_words[0] = 8'hFF; ld_words[1] = 8'h00;
    r0 = rd_seen.size();
    do_load(100, -1, -1, -1, 0);
    ck("chain_FF00", chain_a, 16'hFF00);
    ck("rd_pair_count", rd_seen.size() - r0, 2);
    if (rd_seen.size() >= r0 + 2) begin
      ck("rd_first", rd_seen[r0], 8'hA5);
      ck("rd_second", rd_seen[r0+1], 8'h3C);
    end

    // 12-bit chain with a partial last word
    sel = 1;
    ld_words[0] = 8'hB7; ld_words[1] = 8'h9F;
    r0 = rd_seen.size();
    @(posedge clk); #1;
    do_load(100, -1, -1, -1, 0);
    ck("chain_B79", chain_b, 12'hB79);
    if (rd_seen.size() >= r0 + 2) begin
      ck("rd12_first", rd_seen[r0], 8'h5A);
      ck("rd12_partial", rd_seen[r0+1], 8'h30);
    end else ck("rd12_count", rd_seen.size() - r0, 2);

    // stall between words, abort, start while busy, reset mid-shift
    sel = 0;
    @(posedge clk); #1;
    ld_words[0] = 8'h5C; ld_words[1] = 8'hE1;
    do_load(100, -1, -1, -1, 1);
    do_load(100, 2, -1, -1, 0);
    ld_words[0] = 8'h96; ld_words[1] = 8'h4B;
    do_load(100, -1, -1, -1, 0);
    do_load(100, -1, 5, -1, 0);
    do_load(100, -1, -1, 3, 0);
    ck("post_rst_busy", a_busy, 0);
    ld_words[0] = 8'h71; ld_words[1] = 8'hD8;
    do_load(100, -1, -1, -1, 0);

    // randomized loads
    for (int n = 0; n < 30; n++) begin
      sel = 1'($urandom_range(1));
      lc = sel ? 12 : 16;
      ld_words[0] = 8'($urandom); ld_words[1] = 8'($urandom);
      ab = ($urandom_range(4) == 0) ? int'($urandom_range(lc - 1)) : -1;
      @(posedge clk); #1;
      do_load(int'($urandom_range(100, 30)), ab, -1, -1, 0);
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
